// File: rtl/if_id_fetch_buffer_pkg.sv
// ---------------------------------------------------------------------------
// if_id_fetch_buffer_pkg
//   Shared constants for the IF/ID decoupling buffer.
//   - INST_ADDR_W / INST_DATA_W : default PC and instruction widths (InstAddrBus / InstBus)
//   - FB_DEPTH                  : default queue depth
//   - RST_ENABLE / RST_DISABLE  : rst_n levels (reset is active-low)
//   - INST_NOP                  : canonical RV NOP (addi x0, x0, 0)
// ---------------------------------------------------------------------------
package if_id_fetch_buffer_pkg;

    localparam int          INST_ADDR_W = 64;
    localparam int          INST_DATA_W = 32;
    localparam int          FB_DEPTH    = 2;

    localparam logic        RST_ENABLE  = 1'b0;
    localparam logic        RST_DISABLE = 1'b1;

    localparam logic [31:0] INST_NOP    = 32'h0000_0013;

endpackage : if_id_fetch_buffer_pkg

// File: rtl/if_id_fetch_buffer_fifo_mem.sv
// ---------------------------------------------------------------------------
// if_id_fifo_mem
//   Storage array for the IF/ID buffer. One synchronous write port and one
//   combinational read port. Contents are deliberately not reset: the
//   control logic never presents an entry that has not been written.
//   Ports:
//     clk      : clock
//     we_i     : write enable
//     waddr_i  : write index
//     wdata_i  : {pc, inst} entry to store
//     raddr_i  : read index (head of queue)
//     rdata_o  : entry at raddr_i
// ---------------------------------------------------------------------------
module if_id_fifo_mem #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 96,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [PTR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [PTR_W-1:0] raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : if_id_fifo_mem

// File: rtl/if_id_fetch_buffer.sv
// ---------------------------------------------------------------------------
// if_id_fetch_buffer
//   In-order queue of {pc, inst} pairs between fetch and decode. Absorbs
//   decode stalls; a redirect flush drops every queued entry. All handshake
//   outputs come from registered state only (no in_* -> out_* paths).
//   Ports:
//     clk, rst_n          : clock, synchronous active-low reset
//     flush_i             : redirect, empties the buffer
//     in_valid/in_ready   : fetch-side handshake (in_ready = !full)
//     in_pc, in_inst      : fetched pair
//     out_valid/out_ready : decode-side handshake (out_valid = !empty)
//     out_pc, out_inst    : head pair (0 / NOP when empty)
//     count_o             : occupancy 0..DEPTH
// ---------------------------------------------------------------------------
module if_id_fetch_buffer
    import if_id_fetch_buffer_pkg::*;
#(
    parameter int ADDR_W = INST_ADDR_W,
    parameter int INST_W = INST_DATA_W,
    parameter int DEPTH  = FB_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_W-1:0]        in_pc,
    input  logic [INST_W-1:0]        in_inst,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ADDR_W-1:0]        out_pc,
    output logic [INST_W-1:0]        out_inst,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int ENTRY_W = ADDR_W + INST_W;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;

    logic               push;
    logic               pop;
    logic               empty;
    logic               full;
    logic [ENTRY_W-1:0] head_entry;

    // Full/empty come from the occupancy counter, never from pointer compare.
    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);

    assign in_ready  = ~full;
    assign out_valid = ~empty;
    assign count_o   = count_q;

    assign push = in_valid  & ~full  & ~flush_i;
    assign pop  = out_ready & ~empty & ~flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;   // wraps mod DEPTH
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n == RST_ENABLE) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    if_id_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i ({in_pc, in_inst}),
        .raddr_i (rd_ptr_q),
        .rdata_o (head_entry)
    );

    // Mask the array when empty so decode never sees a stale or unwritten word.
    assign out_pc   = empty ? '0 : head_entry[ENTRY_W-1:INST_W];
    assign out_inst = empty ? INST_W'(INST_NOP) : head_entry[INST_W-1:0];

endmodule : if_id_fetch_buffer
